// File: rtl/serial_fa_adder_pkg.sv
// Shared types for the bit-serial full-adder based adder.
package serial_fa_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_fa_adder_fa.sv
// Single-bit full-adder cell: one bit of sum plus carry-out.
module serial_fa_adder_fa (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_fa_adder.sv
// Bit-serial WIDTH-bit adder: operands are fed LSB-first through one
// full-adder cell, with the carry recirculated through a register.
module serial_fa_adder
  import serial_fa_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [WIDTH-1:0]   s_reg;
  logic [WIDTH-1:0]   s_next;
  logic               carry;
  logic               cout_reg;
  logic [CNT_W-1:0]   cnt;
  logic               fa_s;
  logic               fa_cout;
  logic               last_bit;

  // The full-adder sees the current operand LSBs and the recirculated carry.
  serial_fa_adder_fa u_fa (
    .A    (a_reg[0]),
    .B    (b_reg[0]),
    .Cin  (carry),
    .S    (fa_s),
    .Cout (fa_cout)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  // State register; reset returns to IDLE and drops any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; start is only honoured in IDLE or DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = start ? SHIFT : IDLE;
      SHIFT:   state_next = last_bit ? DONE : SHIFT;
      DONE:    state_next = start ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded straight from the state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      SHIFT:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // New sum bit enters at the MSB so the LSB-first result lands in place.
  always_comb begin
    s_next            = s_reg >> 1;
    s_next[WIDTH-1]   = fa_s;
  end

  // Datapath: load on accepted start, shift one bit per clock while SHIFTing.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      s_reg    <= '0;
      carry    <= 1'b0;
      cout_reg <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_reg <= A;
            b_reg <= B;
            carry <= Cin;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          s_reg <= s_next;
          a_reg <= a_reg >> 1;
          b_reg <= b_reg >> 1;
          carry <= fa_cout;
          cnt   <= cnt + CNT_W'(1);
          if (last_bit) begin
            cout_reg <= fa_cout;
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

  assign S    = s_reg;
  assign Cout = cout_reg;

endmodule

// File: tb/tb_serial_fa_adder.sv
// Self-checking bench for serial_fa_adder: 8-bit and 1-bit builds.
module tb_serial_fa_adder;

  logic       clk;
  logic       rst;

  logic       start8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       cin8;
  logic       busy8;
  logic       done8;
  logic [7:0] s8;
  logic       cout8;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       cin1;
  logic       busy1;
  logic       done1;
  logic [0:0] s1;
  logic       cout1;

  int checks;
  int fails;

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] exp_s;
    logic       exp_cout;
  } vec_t;

  vec_t vecs[5];

  serial_fa_adder #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .A     (a8),
    .B     (b8),
    .Cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .S     (s8),
    .Cout  (cout8)
  );

  serial_fa_adder #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (start1),
    .A     (a1),
    .B     (b1),
    .Cin   (cin1),
    .busy  (busy1),
    .done  (done1),
    .S     (s1),
    .Cout  (cout1)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one addition on the chosen build; returns result, done latency
  // (in cycles after the accepting edge) and number of busy cycles seen.
  task automatic applyStimulus(input bit w1, input logic [7:0] a, input logic [7:0] b,
                               input logic cin, output logic [7:0] s, output logic co,
                               output int lat, output int busy_cnt);
    @(negedge clk);
    if (w1) begin
      a1 = a[0:0]; b1 = b[0:0]; cin1 = cin; start1 = 1'b1;
    end else begin
      a8 = a; b8 = b; cin8 = cin; start8 = 1'b1;
    end
    @(negedge clk);
    start8 = 1'b0;
    start1 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
    lat = -1;
    busy_cnt = 0;
    for (int n = 1; n <= 40; n++) begin
      if (w1 ? done1 : done8) begin
        lat = n;
        break;
      end
      if (w1 ? busy1 : busy8) busy_cnt++;
      @(negedge clk);
    end
    s  = w1 ? {7'b0, s1} : s8;
    co = w1 ? cout1 : cout8;
  endtask

  initial begin
    logic [7:0] s;
    logic       co;
    logic [8:0] ref_sum;
    logic [7:0] ra, rb;
    logic       rc;
    logic [7:0] s_keep;
    int         lat, bc, dones, gap;

    checks = 0;
    fails  = 0;
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;

    vecs[0] = '{"add_0f_01",    8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    vecs[1] = '{"add_ff_01",    8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{"add_ff_ff_c1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{"add_12_34",    8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vecs[4] = '{"add_00_00_c1", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_busy", 32'(busy8), 0);
    checkOutput("reset_done", 32'(done8), 0);
    checkOutput("reset_s",    32'(s8), 0);
    checkOutput("reset_cout", 32'(cout8), 0);
    checkOutput("reset_w1",   32'({busy1, done1, s1, cout1}), 0);

    // Directed table.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, vecs[i].a, vecs[i].b, vecs[i].cin, s, co, lat, bc);
      checkOutput({vecs[i].name, "_s"},    32'(s),  32'(vecs[i].exp_s));
      checkOutput({vecs[i].name, "_cout"}, 32'(co), 32'(vecs[i].exp_cout));
      checkOutput({vecs[i].name, "_lat"},  32'(lat), 9);
      checkOutput({vecs[i].name, "_busy"}, 32'(bc), 8);
    end

    // Random operands against plain arithmetic.
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      ref_sum = 9'(ra) + 9'(rb) + 9'(rc);
      applyStimulus(1'b0, ra, rb, rc, s, co, lat, bc);
      checkOutput("rand_sum", 32'({co, s}), 32'(ref_sum));
      checkOutput("rand_lat", 32'(lat), 9);
    end

    // start during SHIFT must be ignored.
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    dones = 0; lat = -1; s_keep = '0; co = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      if (done8) begin
        dones++;
        if (lat < 0) begin
          lat = n; s_keep = s8; co = cout8;
        end
      end
      if (n == 3) begin
        a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
      end
      if (n == 4) start8 = 1'b0;
      @(negedge clk);
    end
    checkOutput("ignore_s",     32'(s_keep), 32'h46);
    checkOutput("ignore_cout",  32'(co), 0);
    checkOutput("ignore_lat",   32'(lat), 9);
    checkOutput("ignore_dones", 32'(dones), 1);

    // Reset in the middle of an operation.
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_state", 32'({busy8, done8}), 0);
    checkOutput("midrst_s",     32'(s8), 0);
    checkOutput("midrst_cout",  32'(cout8), 0);
    dones = 0;
    for (int n = 0; n < 15; n++) begin
      if (done8) dones++;
      @(negedge clk);
    end
    checkOutput("midrst_nodone", 32'(dones), 0);
    applyStimulus(1'b0, 8'h01, 8'h01, 1'b0, s, co, lat, bc);
    checkOutput("after_rst_sum", 32'({co, s}), 32'h002);

    // Back-to-back with start held high.
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
    gap = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (done8) begin
        gap = n;
        break;
      end
    end
    checkOutput("b2b_first_lat", 32'(gap), 9);
    for (int p = 0; p < 3; p++) begin
      checkOutput("b2b_sum", 32'({cout8, s8}), 32'h100);
      if (p < 2) begin
        gap = -1;
        for (int n = 1; n <= 20; n++) begin
          @(negedge clk);
          if (done8) begin
            gap = n;
            break;
          end
        end
        checkOutput("b2b_period", 32'(gap), 9);
      end
    end
    @(negedge clk);
    start8 = 1'b0;
    checkOutput("b2b_reloaded_busy", 32'(busy8), 1);
    for (int n = 0; n < 20 && !done8; n++) @(negedge clk);
    checkOutput("b2b_last_done", 32'(done8), 1);
    @(negedge clk);
    checkOutput("b2b_idle", 32'({busy8, done8}), 0);

    // One-bit build: full-adder truth table.
    for (int i = 0; i < 8; i++) begin
      ra = 8'(i & 1); rb = 8'((i >> 1) & 1); rc = 1'((i >> 2) & 1);
      ref_sum = 9'(ra) + 9'(rb) + 9'(rc);
      applyStimulus(1'b1, ra, rb, rc, s, co, lat, bc);
      checkOutput("w1_sum",  32'({co, s[0]}), 32'(ref_sum[1:0]));
      checkOutput("w1_lat",  32'(lat), 2);
      checkOutput("w1_busy", 32'(bc), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
